// File: rtl/core_pkg.sv
// Shared fetch-path types: address/instruction widths and the {pc, instr} entry
// that travels from the fetch queue into the IF/ID register.
package core_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries with pointer/count bookkeeping and a
// single-cycle flush that empties it on a redirect.
module fq_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents are only observable through
  // count, which is reset, so clearing the RAM would add logic for no benefit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one-cycle-latency imem
// requests under a credit limit and buffers {pc, instr} for decode.
module fetch_queue
  import core_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic [ENTRY_W-1:0] head_raw;

  // A request reserves a slot until its response lands, so the FIFO can never
  // be asked to accept more than it holds.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = !rst && !redirect && (occupancy < DEPTH_C);

  assign imem_req  = issue;
  assign imem_addr = pc;

  assign push      = inflight && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign push_entry.pc    = req_pc;
  assign push_entry.instr = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + PC_STEP;
        req_pc <= pc;
      end
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .count     (count)
  );

  assign head_entry = fetch_entry_t'(head_raw);
  assign out_valid  = (count != '0);
  assign out_pc     = out_valid ? head_entry.pc    : '0;
  assign out_instr  = out_valid ? head_entry.instr : '0;

  no_push_when_full : assert property (
    @(posedge clk) disable iff (rst) push |-> (count != CNT_W'(DEPTH))
  );

endmodule
